// File: rtl/tmr0_pkg.sv
// Shared constants and helpers for the timer0 sequencer.
// OPTION layout: bit5 t0cs, bit4 t0se, bit3 psa, bits2:0 ps, bits7:6 stored only.
package tmr0_pkg;

    localparam int T0CS_BIT = 5;
    localparam int T0SE_BIT = 4;
    localparam int PSA_BIT  = 3;
    localparam int PS_MSB   = 2;
    localparam int PS_LSB   = 0;

    localparam logic [7:0] OPTION_RST = 8'hFF;
    localparam logic [7:0] TMR0_RST   = 8'h00;

    typedef logic [2:0] ps_t;

    // Terminal count of the prescaler for ratio 2^(ps+1): 1, 3, 7, ... 255.
    function automatic logic [7:0] presc_max(input ps_t ps);
        presc_max = 8'hFF >> (3'd7 - ps);
    endfunction

endpackage

// File: rtl/tmr0_ctrl_if.sv
// CPU register-file side of timer0: write strobes, shared write data,
// flag clear and the register read-back / status outputs.
interface tmr0_ctrl_if;

    logic       wr_option;
    logic       wr_tmr0;
    logic [7:0] wdata;
    logic       clr_t0if;
    logic [7:0] tmr0;
    logic [7:0] option_reg;
    logic       t0if;
    logic       tick;

    modport master (
        output wr_option, wr_tmr0, wdata, clr_t0if,
        input  tmr0, option_reg, t0if, tick
    );

    modport slave (
        input  wr_option, wr_tmr0, wdata, clr_t0if,
        output tmr0, option_reg, t0if, tick
    );

endinterface

// File: rtl/tmr0_edge_sync.sv
// Synchroniser for the asynchronous t0clk pin, followed by a history flop and
// a polarity-selected single-fosc edge pulse (t0se=0 rising, t0se=1 falling).
// SYNC_STAGES must be at least 2.
module tmr0_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic fosc,
    input  logic mclr,
    input  logic t0clk,
    input  logic t0se,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the pin through the synchroniser and remember the previous synced value.
    always_ff @(posedge fosc or negedge mclr) begin
        if (!mclr) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], t0clk};
            hist_q <= synced;
        end
    end

    assign pulse = t0se ? (hist_q & ~synced) : (synced & ~hist_q);

endmodule

// File: rtl/tmr0_ctrl.sv
// Timer0 sequencer in the fosc domain: instruction-cycle strobe, source
// selection, prescaler, TMR0 increment with post-write inhibit, T0IF flag.
// Optional build macro TMR0_GATE_EN adds the t0gate input that suppresses src.
module tmr0_ctrl
    import tmr0_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int INHIBIT_CYCLES = 2
) (
    input  logic        fosc,
    input  logic        mclr,
    input  logic        t0clk,
`ifdef TMR0_GATE_EN
    input  logic        t0gate,
`endif
    tmr0_ctrl_if.slave  bus
);

    localparam int INH_W = (INHIBIT_CYCLES < 1) ? 1 : $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES);

    logic [1:0]       q_q;
    logic             cyc;
    logic [7:0]       option_q, option_d;
    logic [7:0]       tmr0_q, tmr0_d;
    logic [7:0]       presc_q, presc_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic             t0if_q, t0if_d;
    logic             tick_q;
    logic             ext_pulse;
    logic             src_raw;
    logic             src;
    logic             inc_issue;
    logic             inc_fire;
    logic             opt_chg;
    logic [7:0]       presc_tc;

    assign cyc = (q_q == 2'd3);

    // Free-running quarter-cycle phase; cyc marks the last quarter.
    always_ff @(posedge fosc or negedge mclr) begin
        if (!mclr) q_q <= 2'd0;
        else       q_q <= q_q + 2'd1;
    end

    tmr0_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .fosc  (fosc),
        .mclr  (mclr),
        .t0clk (t0clk),
        .t0se  (option_q[T0SE_BIT]),
        .pulse (ext_pulse)
    );

    // Source selection uses the option value currently held, so a src in the
    // same cycle as an OPTION write is judged by the old settings.
    assign src_raw  = option_q[T0CS_BIT] ? ext_pulse : cyc;
`ifdef TMR0_GATE_EN
    assign src      = src_raw & t0gate;
`else
    assign src      = src_raw;
`endif

    assign presc_tc = presc_max(option_q[PS_MSB:PS_LSB]);
    assign opt_chg  = bus.wr_option &&
                      ((bus.wdata[PSA_BIT] != option_q[PSA_BIT]) ||
                       (bus.wdata[PS_MSB:PS_LSB] != option_q[PS_MSB:PS_LSB]));

    // Next-state for prescaler, TMR0, inhibit, flag and OPTION.
    always_comb begin
        presc_d   = presc_q;
        inc_issue = 1'b0;
        if (option_q[PSA_BIT]) begin
            presc_d   = '0;
            inc_issue = src;
        end else if (src) begin
            if (presc_q == presc_tc) begin
                presc_d   = '0;
                inc_issue = 1'b1;
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
        if (bus.wr_tmr0 || opt_chg) presc_d = '0;

        // A TMR0 write overrides an increment landing on the same edge.
        inc_fire = inc_issue && (inh_q == '0) && !bus.wr_tmr0;

        tmr0_d = tmr0_q;
        if (bus.wr_tmr0)   tmr0_d = bus.wdata;
        else if (inc_fire) tmr0_d = tmr0_q + 8'd1;

        inh_d = inh_q;
        if (bus.wr_tmr0)              inh_d = INH_LOAD;
        else if (cyc && inh_q != '0)  inh_d = inh_q - INH_W'(1);

        // Overflow set has priority over a software clear.
        t0if_d = (inc_fire && (tmr0_q == 8'hFF)) || (t0if_q && !bus.clr_t0if);

        option_d = bus.wr_option ? bus.wdata : option_q;
    end

    // Register update for all timer state.
    always_ff @(posedge fosc or negedge mclr) begin
        if (!mclr) begin
            option_q <= OPTION_RST;
            tmr0_q   <= TMR0_RST;
            presc_q  <= '0;
            inh_q    <= '0;
            t0if_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            option_q <= option_d;
            tmr0_q   <= tmr0_d;
            presc_q  <= presc_d;
            inh_q    <= inh_d;
            t0if_q   <= t0if_d;
            tick_q   <= inc_fire;
        end
    end

    assign bus.tmr0       = tmr0_q;
    assign bus.option_reg = option_q;
    assign bus.t0if       = t0if_q;
    assign bus.tick       = tick_q;

endmodule

// File: doc/tmr0_ctrl.md
Name: tmr0_ctrl

Overview:
Synchronous sequencer for the 8-bit timer0 resource, in the fosc domain. Generates the instruction-cycle strobe (fosc/4) and synchronises and edge-qualifies the external t0clk pin. Sequences the prescaler and TMR0 increment, including the 2-cycle increment inhibit after a TMR0 write. Owns the OPTION register, the TMR0 register and the T0IF overflow flag for the CPU register-file interface.

Parameters:
SYNC_STAGES, 2, flops in the t0clk synchroniser (minimum 2)
INHIBIT_CYCLES, 2, instruction cycles of increment suppression after a TMR0 write

Ports:
fosc  in  1  system clock; all state on rising edge
mclr  in  1  reset, asynchronous, active-low
wr_option  in  1  one-fosc write strobe for OPTION
wr_tmr0  in  1  one-fosc write strobe for TMR0
wdata  in  8  write data for either strobe
clr_t0if  in  1  one-fosc strobe clearing T0IF
t0clk  in  1  external timer pin, asynchronous to fosc
tmr0  out  8  current timer value
option_reg  out  8  bit5 t0cs, bit4 t0se, bit3 psa, bits2:0 ps; bits7:6 stored but unused
t0if  out  1  overflow flag, sticky
tick  out  1  one-fosc pulse, high in the cycle after tmr0 increments

Behaviour:
- Reset (mclr=0, async): tmr0=8'h00, option_reg=8'hFF, t0if=0, tick=0, q phase=0, prescaler=0, inhibit=0, synchroniser flops=0.
- Q counter: 2-bit, increments every fosc and wraps 3->0. cyc strobe is high when q==3.
- Source pulse src:
  - t0cs=0: src=cyc.
  - t0cs=1: t0clk passes through SYNC_STAGES flops plus one history flop. t0se=0 selects rising edge, t0se=1 falling edge. src is high one fosc, detected on the synchronised value.
  - Default latency: a pin transition before fosc edge 1 increments tmr0 at edge 3 (psa=1).
- Prescaler: 8-bit counter, ratio R=2^(ps+1), so 2..256.
  - psa=0: each src increments the prescaler. When prescaler==R-1 it wraps to 0 and an increment is issued.
  - psa=1: each src issues an increment directly; the prescaler is held at 0.
- Increment issued with inhibit==0: tmr0<=tmr0+1 (mod 256) and tick asserts the next cycle. If tmr0 was 8'hFF, tmr0 becomes 8'h00 and t0if<=1 on the same edge.
- wr_tmr0:
  - tmr0<=wdata, prescaler<=0, inhibit<=INHIBIT_CYCLES.
  - While inhibit>0, src is still counted by the prescaler logic, but increments are discarded.
  - inhibit decrements on each cyc.
- wr_option: option_reg<=wdata. If psa or ps changes, prescaler<=0 on the same edge.
- Simultaneous events:
  - wr_tmr0 with an issued increment: the write wins; no increment, no t0if set.
  - wr_option with wr_tmr0: both take effect.
  - t0if set with clr_t0if: the set wins.
  - A src landing in the same cycle as a t0cs/t0se change is evaluated with the old option value.
- Reset mid-count: all state returns to reset values immediately. The first increment after release obeys the normal sync latency.

Optional Feature:
TMR0_GATE_EN: adds input port t0gate (1 bit). When t0gate=0, src is forced low: prescaler and tmr0 hold, and inhibit still decrements on cyc. Without the macro, the port is absent and src is never gated.

Decomposition:
- Package tmr0_pkg holds:
  - OPTION bit indices: T0CS_BIT=5, T0SE_BIT=4, PSA_BIT=3, PS_MSB=2, PS_LSB=0.
  - OPTION_RST=8'hFF, TMR0_RST=8'h00.
  - Typedef for the 3-bit ps field.
  - Function returning R-1 from ps.
- One sub-module, tmr0_edge_sync: synchroniser plus history flop plus polarity-selected single-pulse edge detect. Parameterised by SYNC_STAGES, reset by mclr.

Test Plan:
- Reset, then t0cs=0, psa=1: tmr0 increments every 4 fosc. After 1024 fosc, tmr0 has wrapped once, t0if=1 and 256 tick pulses have been counted.
- t0cs=1, t0se=0, psa=0, ps=3'b001 (R=4): 8 rising t0clk edges spaced 10 fosc apart -> tmr0=2. Falling edges do not count. With t0se=1, only falling edges count.
- wr_tmr0 wdata=8'hFE with t0cs=0, psa=1: no increment for 2 instruction cycles, then tmr0 goes FE->FF->00, t0if=1 at the 00 edge. The prescaler reads 0 after the write.
- Increment and wr_tmr0 (wdata=8'h10) on the same edge: tmr0=8'h10, t0if unchanged. An increment and clr_t0if on the FF->00 edge leaves t0if=1.
- psa=0, ps=7, prescaler at 100: wr_option changing ps to 6 -> prescaler=0, and the next increment comes after 128 src pulses.
- mclr pulsed low mid-count with tmr0=8'h5A, option_reg=8'h07: all outputs return to reset values immediately. With TMR0_GATE_EN, t0gate=0 for 40 fosc with t0cs=0, psa=1 leaves tmr0 unchanged.
